bit_stream_addsub: RTL and testbench
====================================

// Module: bit_stream_addsub
// PURPOSE
//  Parametrised successor to the single-channel bit-serial adder FSM. Adds or subtracts
//  N_CH independent serial operand streams, DIGIT_W bits per clock, LSB digit first.
//  Operands are framed by sof/eof markers; carry is cleared or preset at each frame start.
//  Final carry and signed overflow are reported per channel at frame end.
//  Sits between serial operand sources and a serial result sink in the stream datapath.
// PARAMETERS
//  DIGIT_W  1  bits per channel per digit (>=1)
//  N_CH     1  number of independent channels sharing one framing/handshake
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  in_valid   in   1             digit on a/b is valid this cycle
//  in_sof     in   1             first (least significant) digit of a frame; qualified by in_valid
//  in_eof     in   1             last (most significant) digit of a frame; qualified by in_valid
//  sub        in   1             0 = a+b, 1 = a-b; sampled only on sof digit, held for the frame
//  a          in   N_CH*DIGIT_W  operand A digits; channel k = a[k*DIGIT_W +: DIGIT_W]
//  b          in   N_CH*DIGIT_W  operand B digits, same packing
//  out_valid  out  1             y holds a result digit
//  out_sof    out  1             y is the first digit of a result frame
//  out_eof    out  1             y is the last digit; carry_out/ovf valid
//  y          out  N_CH*DIGIT_W  result digits, same packing as a
//  carry_out  out  N_CH          carry out of final MSB (sub: 1 = no borrow); valid with out_eof
//  ovf        out  N_CH          signed two's-complement overflow; valid with out_eof
//  frame_err  out  1             one-cycle pulse on framing violation
// BEHAVIOUR
//  - Reset: state IDLE, carry regs 0, latched mode 0, all outputs 0. Reset mid-frame
//    discards the frame; no out_eof is produced for it.
//  - Latency: exactly 1 clk, all outputs registered. No backpressure; sink must accept every digit.
//  - Per digit, per channel: bb = sub_eff ? ~b : b; {c, y} = a + bb + cin (DIGIT_W+1 bits).
//    cin = sub on sof digit, else stored carry of that channel. Stored carry <= c.
//  - ovf on eof digit = carry into MSB bit XOR carry out of MSB bit; carry_out = c.
//  - carry_out/ovf are 0 whenever out_eof = 0.
//  - FSM IDLE: valid&sof&!eof -> RUN; valid&sof&eof -> single-digit frame, stay IDLE;
//    valid&!sof -> digit dropped (out_valid=0), frame_err pulse, stay IDLE.
//  - FSM RUN: valid&!sof&!eof -> process, stay; valid&eof -> process, out_eof, -> IDLE;
//    valid&sof -> frame_err pulse, old frame aborted (no out_eof), digit starts new frame
//    (cin=sub, mode relatched), -> RUN or IDLE per eof.
//  - in_valid=0 (stall): state, carries, mode held; out_valid=0 next cycle; y holds last value.
//  - sub changes mid-frame are ignored. in_sof/in_eof/sub ignored when in_valid=0.
//  - Channels share state/mode; arithmetic and flags are fully independent per channel.
// TESTING (LSB digit first)
//  1. DIGIT_W=1,N_CH=1, add: a=0,1,1,0 b=1,1,1,0 (6+7) -> y=1,0,1,1 (13), carry_out=0, ovf=1.
//  2. DIGIT_W=1, sub=1: a=1,0,1,0 b=1,1,0,0 (5-3) -> y=0,1,0,0 (2), carry_out=1, ovf=0.
//  3. Test 1 with in_valid=0 bubbles between each digit -> identical y/flags; out_valid low
//     exactly one cycle after each bubble.
//  4. DIGIT_W=4,N_CH=2, 2-digit frame: ch0 0xFF+0x01 -> y=0x00, carry_out=1, ovf=0;
//     ch1 0x7F+0x01 -> y=0x80, carry_out=0, ovf=1.
//  5. Framing: digit without sof in IDLE -> frame_err=1, out_valid=0; sof in RUN -> frame_err=1,
//     no out_eof for old frame, new frame result correct (carry restarted).
//  6. rst_n low mid-frame (async, between edges) -> all outputs 0 immediately; next non-sof
//     digit -> frame_err; fresh sof frame computes correctly.

Source files
------------

// File: rtl/bit_stream_addsub.sv
// Multi-channel bit-serial adder/subtractor: DIGIT_W bits per channel per clock, LSB digit first,
// framed by sof/eof, with per-channel final carry and signed overflow reported on the eof digit.
`timescale 1ns/1ps
module bit_stream_addsub #(
    parameter int DIGIT_W = 1,
    parameter int N_CH    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic                      in_eof,
    input  logic                      sub,
    input  logic [N_CH*DIGIT_W-1:0]   a,
    input  logic [N_CH*DIGIT_W-1:0]   b,
    output logic                      out_valid,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic [N_CH*DIGIT_W-1:0]   y,
    output logic [N_CH-1:0]           carry_out,
    output logic [N_CH-1:0]           ovf,
    output logic                      frame_err
);
    localparam int TW = N_CH * DIGIT_W;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic              mode_reg, mode_next;
    logic [N_CH-1:0]   carry_reg, carry_next;
    logic [TW-1:0]     y_reg, y_next;
    logic              out_valid_reg, out_valid_next;
    logic              out_sof_reg, out_sof_next;
    logic              out_eof_reg, out_eof_next;
    logic [N_CH-1:0]   carry_out_reg, carry_out_next;
    logic [N_CH-1:0]   ovf_reg, ovf_next;
    logic              frame_err_reg, frame_err_next;

    logic              start;
    logic              accept;
    logic              sub_eff;
    logic [DIGIT_W:0]  sum_w [N_CH];
    logic [N_CH-1:0]   c_w;
    logic [N_CH-1:0]   v_w;

    // A sof digit always opens a frame; otherwise only digits inside a frame are processed.
    assign start   = in_valid & in_sof;
    assign accept  = in_valid & (in_sof | (state_reg == RUN));
    assign sub_eff = start ? sub : mode_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DIGIT_W-1:0] a_d;
            logic [DIGIT_W-1:0] bb_d;
            logic               cin;

            assign a_d  = a[gi*DIGIT_W +: DIGIT_W];
            assign bb_d = sub_eff ? ~b[gi*DIGIT_W +: DIGIT_W] : b[gi*DIGIT_W +: DIGIT_W];
            assign cin  = start ? sub : carry_reg[gi];
            assign sum_w[gi] = {1'b0, a_d} + {1'b0, bb_d} + {{DIGIT_W{1'b0}}, cin};
            assign c_w[gi]   = sum_w[gi][DIGIT_W];
            // Carry into the MSB recovered as a^b^sum at that bit position.
            assign v_w[gi]   = c_w[gi] ^ (a_d[DIGIT_W-1] ^ bb_d[DIGIT_W-1] ^ sum_w[gi][DIGIT_W-1]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        carry_next     = carry_reg;
        y_next         = y_reg;
        out_valid_next = 1'b0;
        out_sof_next   = 1'b0;
        out_eof_next   = 1'b0;
        carry_out_next = '0;
        ovf_next       = '0;
        frame_err_next = 1'b0;

        if (in_valid && (state_reg == IDLE) && !in_sof) begin
            frame_err_next = 1'b1;
        end
        if (in_valid && (state_reg == RUN) && in_sof) begin
            frame_err_next = 1'b1;
        end
        if (start) begin
            mode_next = sub;
        end
        if (accept) begin
            out_valid_next = 1'b1;
            out_sof_next   = in_sof;
            out_eof_next   = in_eof;
            carry_next     = c_w;
            for (int k = 0; k < N_CH; k++) begin
                y_next[k*DIGIT_W +: DIGIT_W] = sum_w[k][DIGIT_W-1:0];
            end
            if (in_eof) begin
                carry_out_next = c_w;
                ovf_next       = v_w;
                state_next     = IDLE;
            end else begin
                state_next     = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg      <= 1'b0;
            carry_reg     <= '0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
            out_sof_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
            carry_out_reg <= '0;
            ovf_reg       <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            mode_reg      <= mode_next;
            carry_reg     <= carry_next;
            y_reg         <= y_next;
            out_valid_reg <= out_valid_next;
            out_sof_reg   <= out_sof_next;
            out_eof_reg   <= out_eof_next;
            carry_out_reg <= carry_out_next;
            ovf_reg       <= ovf_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sof   = out_sof_reg;
    assign out_eof   = out_eof_reg;
    assign y         = y_reg;
    assign carry_out = carry_out_reg;
    assign ovf       = ovf_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_bit_stream_addsub.sv
// Scoreboard bench for bit_stream_addsub: two instances (1-bit/1-channel and 4-bit/2-channel)
// checked against whole-frame integer arithmetic.
`timescale 1ns/1ps
module tb_bit_stream_addsub;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: DIGIT_W=1, N_CH=1
    logic v0, s0, e0, u0;
    logic [0:0] a0, b0, y0, co0, of0;
    logic ov0, os0, oe0, fe0;
    // Instance 1: DIGIT_W=4, N_CH=2
    logic v1, s1, e1, u1;
    logic [7:0] a1, b1, y1;
    logic [1:0] co1, of1;
    logic ov1, os1, oe1, fe1;

    bit_stream_addsub #(.DIGIT_W(1), .N_CH(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_sof(s0), .in_eof(e0), .sub(u0),
        .a(a0), .b(b0), .out_valid(ov0), .out_sof(os0), .out_eof(oe0), .y(y0),
        .carry_out(co0), .ovf(of0), .frame_err(fe0));

    bit_stream_addsub #(.DIGIT_W(4), .N_CH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_sof(s1), .in_eof(e1), .sub(u1),
        .a(a1), .b(b1), .out_valid(ov1), .out_sof(os1), .out_eof(oe1), .y(y1),
        .carry_out(co1), .ovf(of1), .frame_err(fe1));

    typedef struct {
        int         cyc;
        bit         valid;
        bit         sof;
        bit         eof;
        logic [7:0] y;
        logic [1:0] co;
        logic [1:0] ovf;
        bit         fe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic mon(input int d);
        exp_t e;
        bit have;
        logic ov, os, oe, fe;
        logic [7:0] yy;
        logic [1:0] co, of;
        have = 1'b0;
        if (d == 0) begin
            ov = ov0; os = os0; oe = oe0; fe = fe0;
            yy = {7'd0, y0}; co = {1'b0, co0}; of = {1'b0, of0};
            while (q0.size() > 0 && q0[0].cyc < cyc) begin
                e = q0.pop_front();
                check("d0_stale_entry", 32'(e.cyc), 32'(cyc));
            end
            if (q0.size() > 0 && q0[0].cyc == cyc) begin
                e = q0.pop_front();
                have = 1'b1;
            end
        end else begin
            ov = ov1; os = os1; oe = oe1; fe = fe1;
            yy = y1; co = co1; of = of1;
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                e = q1.pop_front();
                check("d1_stale_entry", 32'(e.cyc), 32'(cyc));
            end
            if (q1.size() > 0 && q1[0].cyc == cyc) begin
                e = q1.pop_front();
                have = 1'b1;
            end
        end
        if (have) begin
            check($sformatf("d%0d_out_valid", d), 32'(ov), 32'(e.valid));
            check($sformatf("d%0d_frame_err", d), 32'(fe), 32'(e.fe));
            check($sformatf("d%0d_out_eof", d), 32'(oe), 32'(e.eof));
            if (e.valid) begin
                check($sformatf("d%0d_out_sof", d), 32'(os), 32'(e.sof));
                check($sformatf("d%0d_y", d), 32'(yy), 32'(e.y));
                check($sformatf("d%0d_carry_out", d), 32'(co), 32'(e.co));
                check($sformatf("d%0d_ovf", d), 32'(of), 32'(e.ovf));
            end
        end else begin
            check($sformatf("d%0d_idle_valid", d), 32'(ov), 32'd0);
            check($sformatf("d%0d_idle_err", d), 32'(fe), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0);
            mon(1);
        end
    end

    task automatic drive(input int d, input bit v, input bit s, input bit e, input bit u,
                         input logic [7:0] av, input logic [7:0] bv);
        if (d == 0) begin
            v0 = v; s0 = s; e0 = e; u0 = u; a0 = av[0:0]; b0 = bv[0:0];
        end else begin
            v1 = v; s1 = s; e1 = e; u1 = u; a1 = av; b1 = bv;
        end
    endtask

    task automatic drive_idle(input int d);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Sends the first nsend digits of an nd-digit frame; expectations come from whole-word arithmetic.
    task automatic send_frame(input int d, input int nd, input bit sb, input int nsend,
                              input bit bubbles, input bit sof_err,
                              input logic [63:0] opa0, input logic [63:0] opb0,
                              input logic [63:0] opa1, input logic [63:0] opb1);
        int w, n, t;
        logic [63:0] mask, lim;
        logic [63:0] ua [2];
        logic [63:0] ub [2];
        logic [63:0] r [2];
        bit co [2];
        bit of [2];
        longint sa, sbv, s;
        logic [7:0] abus, bbus, ybus;
        exp_t e;
        w = (d == 0) ? 1 : 4;
        n = (d == 0) ? 1 : 2;
        t = nd * w;
        mask = (64'd1 << t) - 64'd1;
        lim  = 64'd1 << (t - 1);
        ua[0] = opa0 & mask; ub[0] = opb0 & mask;
        ua[1] = opa1 & mask; ub[1] = opb1 & mask;
        for (int ch = 0; ch < 2; ch++) begin
            r[ch]  = sb ? (ua[ch] + ((~ub[ch]) & mask) + 64'd1) : (ua[ch] + ub[ch]);
            co[ch] = r[ch][t];
            sa  = ua[ch][t-1] ? longint'(ua[ch]) - 2 * longint'(lim) : longint'(ua[ch]);
            sbv = ub[ch][t-1] ? longint'(ub[ch]) - 2 * longint'(lim) : longint'(ub[ch]);
            s   = sb ? sa - sbv : sa + sbv;
            of[ch] = (s >= longint'(lim)) || (s < -longint'(lim));
        end
        for (int i = 0; i < nsend; i++) begin
            @(posedge clk); #1;
            abus = '0; bbus = '0; ybus = '0;
            for (int ch = 0; ch < n; ch++) begin
                for (int j = 0; j < w; j++) begin
                    abus[ch*w+j] = ua[ch][i*w+j];
                    bbus[ch*w+j] = ub[ch][i*w+j];
                    ybus[ch*w+j] = r[ch][i*w+j];
                end
            end
            drive(d, 1'b1, i == 0, i == nd - 1, (i == 0) ? sb : 1'($urandom), abus, bbus);
            e.cyc = cyc + 1;
            e.valid = 1'b1;
            e.sof = (i == 0);
            e.eof = (i == nd - 1);
            e.y = ybus;
            e.co = '0;
            e.ovf = '0;
            if (e.eof) begin
                e.co  = (n == 2) ? {co[1], co[0]} : {1'b0, co[0]};
                e.ovf = (n == 2) ? {of[1], of[0]} : {1'b0, of[0]};
            end
            e.fe = (i == 0) && sof_err;
            push(d, e);
            if (bubbles) drive_idle(d);
        end
        drive_idle(d);
    endtask

    // A digit without sof while idle must be dropped and flagged.
    task automatic stray(input int d);
        exp_t e;
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        e.cyc = cyc + 1; e.valid = 1'b0; e.sof = 1'b0; e.eof = 1'b0;
        e.y = '0; e.co = '0; e.ovf = '0; e.fe = 1'b1;
        push(d, e);
        drive_idle(d);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_ov0"}, 32'(ov0), 32'd0);
        check({tag, "_os0"}, 32'(os0), 32'd0);
        check({tag, "_oe0"}, 32'(oe0), 32'd0);
        check({tag, "_y0"},  32'(y0),  32'd0);
        check({tag, "_co0"}, 32'(co0), 32'd0);
        check({tag, "_of0"}, 32'(of0), 32'd0);
        check({tag, "_fe0"}, 32'(fe0), 32'd0);
        check({tag, "_ov1"}, 32'(ov1), 32'd0);
        check({tag, "_os1"}, 32'(os1), 32'd0);
        check({tag, "_oe1"}, 32'(oe1), 32'd0);
        check({tag, "_y1"},  32'(y1),  32'd0);
        check({tag, "_co1"}, 32'(co1), 32'd0);
        check({tag, "_of1"}, 32'(of1), 32'd0);
        check({tag, "_fe1"}, 32'(fe1), 32'd0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int wcnt;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 6+7 add, 5-3 subtract, 6+7 with bubbles
        send_frame(0, 4, 1'b0, 4, 1'b0, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0);
        send_frame(0, 4, 1'b1, 4, 1'b0, 1'b0, 64'd5, 64'd3, 64'd0, 64'd0);
        send_frame(0, 4, 1'b0, 4, 1'b1, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0);
        // Two channels: 0xFF+0x01 and 0x7F+0x01
        send_frame(1, 2, 1'b0, 2, 1'b0, 1'b0, 64'hFF, 64'h01, 64'h7F, 64'h01);

        for (int it = 0; it < 25; it++) begin
            send_frame(0, int'($urandom_range(1, 16)), 1'($urandom), 0, 1'b0, 1'b0,
                       rnd64(), rnd64(), rnd64(), rnd64());
            send_frame(0, 0 + int'($urandom_range(1, 16)), 1'($urandom), 0, 1'b0, 1'b0,
                       rnd64(), rnd64(), rnd64(), rnd64());
        end
        for (int it = 0; it < 25; it++) begin
            int nd0, nd1;
            nd0 = int'($urandom_range(1, 16));
            nd1 = int'($urandom_range(1, 8));
            send_frame(0, nd0, 1'($urandom), nd0, 1'($urandom), 1'b0, rnd64(), rnd64(), rnd64(), rnd64());
            send_frame(1, nd1, 1'($urandom), nd1, 1'($urandom), 1'b0, rnd64(), rnd64(), rnd64(), rnd64());
        end

        // Framing errors: stray digit in IDLE, then sof arriving inside a running frame
        stray(0);
        stray(1);
        send_frame(0, 6, 1'b0, 3, 1'b0, 1'b0, rnd64(), rnd64(), 64'd0, 64'd0);
        send_frame(0, 5, 1'b1, 5, 1'b0, 1'b1, rnd64(), rnd64(), 64'd0, 64'd0);
        send_frame(1, 5, 1'b1, 3, 1'b0, 1'b0, rnd64(), rnd64(), rnd64(), rnd64());
        send_frame(1, 3, 1'b0, 3, 1'b1, 1'b1, rnd64(), rnd64(), rnd64(), rnd64());

        // Asynchronous reset mid-frame, asserted between clock edges
        send_frame(0, 8, 1'b0, 4, 1'b0, 1'b0, rnd64(), rnd64(), 64'd0, 64'd0);
        send_frame(1, 6, 1'b1, 3, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'h1, 64'hFFFF_FFFF, 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        q0.delete();
        q1.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray(0);
        stray(1);
        send_frame(0, 4, 1'b0, 4, 1'b0, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0);
        send_frame(1, 2, 1'b0, 2, 1'b0, 1'b0, 64'hFF, 64'h01, 64'h7F, 64'h01);

        wcnt = 0;
        while ((q0.size() + q1.size()) > 0 && wcnt < 50) begin
            @(posedge clk);
            wcnt++;
        end
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
